// File: rtl/unidade_acesso_memoria.sv
// Load/store unit. It takes one request at a time, forms the address
// base+offset (mod 256) and drives a synchronous data memory. The memory
// writes on the rising edge and updates DadoLido on the falling edge.
module unidade_acesso_memoria (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valido,
  input  logic       req_escrita,
  input  logic [7:0] req_base,
  input  logic [7:0] req_desloc,
  input  logic [7:0] req_dado,
  output logic       pronto,
  output logic       resp_valido,
  output logic [7:0] resp_dado,
  input  logic       resp_pronto,
  output logic [7:0] contador_acessos,
  output logic [7:0] Endereco,
  output logic [7:0] DadoEscrito,
  output logic       EscMem,
  output logic       LerMem,
  input  logic [7:0] DadoLido
);

  typedef enum logic [1:0] {OCIOSO, LEITURA, ESCRITA, RESPOSTA} estado_t;

  estado_t    r_estado, w_prox;
  logic       w_aceita;
  logic       r_esc_mem, r_ler_mem, r_resp_valido;
  logic [7:0] r_endereco, r_dado_escrito, r_resp_dado, r_contador;

  assign pronto   = (r_estado == OCIOSO);
  assign w_aceita = req_valido && (r_estado == OCIOSO);

  // state register
  always_ff @(posedge clock) begin
    if (reset) r_estado <= OCIOSO;
    else       r_estado <= w_prox;
  end

  // next-state decode; store and read phases are one cycle each
  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      OCIOSO:   if (w_aceita) w_prox = req_escrita ? ESCRITA : LEITURA;
      ESCRITA:  w_prox = OCIOSO;
      LEITURA:  w_prox = RESPOSTA;
      RESPOSTA: if (resp_pronto) w_prox = OCIOSO;
      default:  w_prox = OCIOSO;
    endcase
  end

  // datapath and registered memory strobes, derived from the next state so
  // they line up exactly with the state they qualify
  always_ff @(posedge clock) begin
    if (reset) begin
      r_endereco     <= 8'h00;
      r_dado_escrito <= 8'h00;
      r_esc_mem      <= 1'b0;
      r_ler_mem      <= 1'b0;
      r_resp_valido  <= 1'b0;
      r_resp_dado    <= 8'h00;
      r_contador     <= 8'h00;
    end else begin
      if (w_aceita) begin
        r_endereco     <= req_base + req_desloc;
        r_dado_escrito <= req_dado;
      end
      r_esc_mem     <= (w_prox == ESCRITA);
      r_ler_mem     <= (w_prox == LEITURA);
      r_resp_valido <= (w_prox == RESPOSTA);
      // memory data became valid on the falling edge inside LEITURA
      if (r_estado == LEITURA) r_resp_dado <= DadoLido;
      if ((r_estado == ESCRITA) || (r_estado == RESPOSTA && resp_pronto))
        r_contador <= r_contador + 8'd1;
    end
  end

  assign Endereco         = r_endereco;
  assign DadoEscrito      = r_dado_escrito;
  assign EscMem           = r_esc_mem;
  assign LerMem           = r_ler_mem;
  assign resp_valido      = r_resp_valido;
  assign resp_dado        = r_resp_dado;
  assign contador_acessos = r_contador;

endmodule

// File: tb/tb_unidade_acesso_memoria.sv
// Directed bench with a behavioural data memory, a reference memory image
// and a queue of expected load results.
module tb_unidade_acesso_memoria;

  logic       clock = 1'b0;
  logic       reset;
  logic       req_valido, req_escrita, resp_pronto;
  logic [7:0] req_base, req_desloc, req_dado;
  logic       pronto, resp_valido, EscMem, LerMem;
  logic [7:0] resp_dado, contador_acessos, Endereco, DadoEscrito, DadoLido;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];
  logic [7:0] ref_cnt;
  logic [7:0] exp_q [$];

  always #5 clock = ~clock;

  unidade_acesso_memoria dut (
    .clock(clock), .reset(reset),
    .req_valido(req_valido), .req_escrita(req_escrita),
    .req_base(req_base), .req_desloc(req_desloc), .req_dado(req_dado),
    .pronto(pronto), .resp_valido(resp_valido), .resp_dado(resp_dado),
    .resp_pronto(resp_pronto), .contador_acessos(contador_acessos),
    .Endereco(Endereco), .DadoEscrito(DadoEscrito),
    .EscMem(EscMem), .LerMem(LerMem), .DadoLido(DadoLido)
  );

  // data memory: write on rising edge, read data on falling edge
  always @(posedge clock) if (EscMem === 1'b1) mem[Endereco] <= DadoEscrito;
  always @(negedge clock) if (LerMem === 1'b1) DadoLido <= mem[Endereco];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".pronto"},  {7'd0, pronto}, 8'h01);
    chk({tag, ".EscMem"},  {7'd0, EscMem}, 8'h00);
    chk({tag, ".LerMem"},  {7'd0, LerMem}, 8'h00);
    chk({tag, ".Endereco"}, Endereco, 8'h00);
    chk({tag, ".DadoEscrito"}, DadoEscrito, 8'h00);
    chk({tag, ".resp_valido"}, {7'd0, resp_valido}, 8'h00);
    chk({tag, ".resp_dado"}, resp_dado, 8'h00);
    chk({tag, ".contador"}, contador_acessos, 8'h00);
  endtask

  task automatic store(input logic [7:0] b, input logic [7:0] o, input logic [7:0] d, input bit busy);
    logic [7:0] a;
    a = b + o;
    chk("st.pronto_in", {7'd0, pronto}, 8'h01);
    req_valido = 1; req_escrita = 1; req_base = b; req_desloc = o; req_dado = d;
    step();
    ref_mem[a] = d;
    if (busy) begin
      req_base = b ^ 8'h33; req_desloc = o + 8'd7; req_dado = ~d; req_escrita = 0;
    end else req_valido = 0;
    chk("st.EscMem_hi", {7'd0, EscMem}, 8'h01);
    chk("st.LerMem_lo", {7'd0, LerMem}, 8'h00);
    chk("st.pronto_busy", {7'd0, pronto}, 8'h00);
    chk("st.Endereco", Endereco, a);
    chk("st.DadoEscrito", DadoEscrito, d);
    step();
    req_valido = 0;
    ref_cnt = ref_cnt + 8'd1;
    chk("st.EscMem_lo", {7'd0, EscMem}, 8'h00);
    chk("st.pronto_back", {7'd0, pronto}, 8'h01);
    chk("st.Endereco_held", Endereco, a);
    chk("st.contador", contador_acessos, ref_cnt);
  endtask

  task automatic load(input logic [7:0] b, input logic [7:0] o, input int hold, input bit busy);
    logic [7:0] a, e;
    a = b + o;
    exp_q.push_back(ref_mem[a]);
    chk("ld.pronto_in", {7'd0, pronto}, 8'h01);
    req_valido = 1; req_escrita = 0; req_base = b; req_desloc = o; req_dado = 8'hEE;
    resp_pronto = (hold == 0);
    step();
    if (busy) begin
      req_base = b ^ 8'h5C; req_desloc = o + 8'd1; req_dado = 8'h11; req_escrita = 1;
    end else req_valido = 0;
    chk("ld.LerMem_hi", {7'd0, LerMem}, 8'h01);
    chk("ld.pronto_busy", {7'd0, pronto}, 8'h00);
    chk("ld.resp_valido_early", {7'd0, resp_valido}, 8'h00);
    chk("ld.Endereco", Endereco, a);
    step();
    req_valido = 0;
    chk("ld.resp_valido", {7'd0, resp_valido}, 8'h01);
    chk("ld.LerMem_lo", {7'd0, LerMem}, 8'h00);
    chk("ld.Endereco_held", Endereco, a);
    if (exp_q.size() > 0) e = exp_q.pop_front(); else e = 8'hXX;
    chk("ld.resp_dado", resp_dado, e);
    for (int i = 0; i < hold; i++) begin
      step();
      chk("ld.hold_valido", {7'd0, resp_valido}, 8'h01);
      chk("ld.hold_dado", resp_dado, e);
      chk("ld.hold_pronto", {7'd0, pronto}, 8'h00);
    end
    resp_pronto = 1;
    step();
    resp_pronto = 0;
    ref_cnt = ref_cnt + 8'd1;
    chk("ld.valido_drop", {7'd0, resp_valido}, 8'h00);
    chk("ld.pronto_back", {7'd0, pronto}, 8'h01);
    chk("ld.dado_kept", resp_dado, e);
    chk("ld.contador", contador_acessos, ref_cnt);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1; req_valido = 0; req_escrita = 0; resp_pronto = 0;
    req_base = 0; req_desloc = 0; req_dado = 0;
    ref_cnt = 0;
    step(); step();
    reset = 0;
    chk_reset_vals("rst");

    // store then load, same address
    store(8'h10, 8'h05, 8'hA5, 0);
    load(8'h15, 8'h00, 0, 0);
    chk("sl.contador", contador_acessos, 8'h02);

    // address wrap
    store(8'hF0, 8'h20, 8'h3C, 0);
    load(8'h10, 8'h00, 0, 0);

    // backpressure: resp_pronto low for 5 cycles
    store(8'h80, 8'h01, 8'h77, 0);
    load(8'h7F, 8'h02, 5, 0);

    // busy rejection during ESCRITA and LEITURA
    store(8'h20, 8'h02, 8'hC3, 1);
    load(8'h22, 8'h00, 0, 1);
    chk("busy.no_accept", {7'd0, LerMem | EscMem}, 8'h00);

    // reset in LEITURA, with a request presented on the reset edge
    req_valido = 1; req_escrita = 0; req_base = 8'h15; req_desloc = 0;
    step();
    chk("rl.LerMem_hi", {7'd0, LerMem}, 8'h01);
    reset = 1; req_escrita = 1; req_dado = 8'h99;
    step();
    reset = 0; req_valido = 0;
    ref_cnt = 0;
    chk_reset_vals("rl");
    step();
    chk("rl.no_valido", {7'd0, resp_valido}, 8'h00);
    chk("rl.pronto", {7'd0, pronto}, 8'h01);

    // reset on the edge leaving ESCRITA: store still lands, no count
    req_valido = 1; req_escrita = 1; req_base = 8'h40; req_desloc = 0; req_dado = 8'h5A;
    step();
    req_valido = 0;
    chk("re.EscMem_hi", {7'd0, EscMem}, 8'h01);
    reset = 1;
    step();
    reset = 0;
    ref_mem[8'h40] = 8'h5A;
    chk_reset_vals("re");
    load(8'h40, 8'h00, 0, 0);

    // counter wrap over 256 stores
    reset = 1;
    step();
    reset = 0;
    ref_cnt = 0;
    chk("cw.start", contador_acessos, 8'h00);
    for (int i = 0; i < 256; i++) store(8'(i), 8'h00, 8'(i) ^ 8'h5A, 0);
    chk("cw.wrap", contador_acessos, 8'h00);
    load(8'h81, 8'h00, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/unidade_acesso_memoria.md
UNIDADE_ACESSO_MEMORIA -- requirements
Module: unidade_acesso_memoria

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: `clock` and `reset`.
REQ-002 The port list SHALL be exactly as follows (name, direction, width, meaning):
- `clock`  input  1  sole clock; all state changes on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `req_valido`  input  1  a requester presents an access.
- `req_escrita`  input  1  1 = store, 0 = load.
- `req_base`  input  8  base address.
- `req_desloc`  input  8  address offset.
- `req_dado`  input  8  store data.
- `pronto`  output  1  unit can accept a request.
- `resp_valido`  output  1  load result is available.
- `resp_dado`  output  8  load result.
- `resp_pronto`  input  1  requester consumes the load result.
- `contador_acessos`  output  8  count of completed accesses.
- `Endereco`  output  8  data-memory address.
- `DadoEscrito`  output  8  data-memory write data.
- `EscMem`  output  1  data-memory write enable; memory writes on the rising edge.
- `LerMem`  output  1  data-memory read enable; memory updates `DadoLido` on the falling edge.
- `DadoLido`  input  8  data-memory read data.

Function
REQ-003 The FSM SHALL have exactly four states: OCIOSO, LEITURA, ESCRITA, RESPOSTA.
REQ-004 `pronto` SHALL be 1 if and only if the state is OCIOSO; it is decoded from the state only.
REQ-005 A request SHALL be accepted on a rising edge when `req_valido`=1 and `pronto`=1. A request with `req_valido`=1 in any other state is ignored and not queued.
REQ-006 On acceptance the block SHALL:
- register `Endereco` = (`req_base` + `req_desloc`) mod 256, discarding the carry (0xF0+0x20 = 0x10);
- register `DadoEscrito` = `req_dado`;
- go to ESCRITA if `req_escrita`=1, otherwise to LEITURA.
REQ-007 `EscMem` SHALL be a registered output equal to 1 only while in ESCRITA.
REQ-008 `LerMem` SHALL be a registered output equal to 1 only while in LEITURA.
REQ-009 `Endereco` and `DadoEscrito` SHALL stay constant from acceptance until the state next returns to OCIOSO.
REQ-010 ESCRITA SHALL last exactly one cycle, so the memory commits the store on the rising edge that leaves ESCRITA. The next state is OCIOSO.
REQ-011 LEITURA SHALL last exactly one cycle. On the rising edge that leaves it:
- capture `DadoLido` into `resp_dado` (memory data is valid since the intervening falling edge);
- go to RESPOSTA.
REQ-012 Load latency SHALL be: acceptance at edge E0, `resp_valido` high from edge E0+1.
REQ-013 Store latency SHALL be: acceptance at edge E0, memory write at E0+1, `pronto` high again after E0+1.
REQ-014 In RESPOSTA:
- `resp_valido` SHALL be 1 and `resp_dado` SHALL be stable;
- on an edge with `resp_pronto`=1 the state SHALL go to OCIOSO and `resp_valido` SHALL drop;
- otherwise the state SHALL be held indefinitely.
REQ-015 `resp_valido` SHALL be 0 in every state other than RESPOSTA; `resp_dado` SHALL keep its last value outside RESPOSTA.
REQ-016 `contador_acessos` SHALL increment by 1, wrapping modulo 256 (0xFF -> 0x00), on:
- the edge leaving ESCRITA;
- the edge leaving RESPOSTA.
REQ-017 Maximum throughput SHALL be:
- one store per 2 cycles;
- one load per 3 cycles when `resp_pronto` is held at 1.
REQ-018 A load issued to the same address immediately after a store SHALL return the stored value; no forwarding is needed because the store commits before the load's read enable.

Reset
REQ-019 While `reset`=1 at a rising edge, the following SHALL hold after that edge: state OCIOSO; `EscMem`=0; `LerMem`=0; `Endereco`=0x00; `DadoEscrito`=0x00; `resp_valido`=0; `resp_dado`=0x00; `contador_acessos`=0x00; `pronto`=1.
REQ-020 `reset` SHALL take priority over acceptance: a request presented on a reset edge is discarded.
REQ-021 Reset asserted on the edge leaving ESCRITA:
- the memory still commits the store, because it samples `EscMem` before it clears;
- the counter does not increment.
REQ-022 Reset asserted in LEITURA or RESPOSTA SHALL discard the pending load; no `resp_valido` pulse follows.

Verification
REQ-023 Store then load:
- stimulus: store base 0x10, offset 0x05, data 0xA5; then load base 0x15, offset 0x00;
- response: `EscMem` high for exactly 1 cycle with `Endereco`=0x15; `resp_dado`=0xA5; `resp_valido` high one edge after load acceptance; `contador_acessos`=0x02.
REQ-024 Address wrap:
- stimulus: store base 0xF0, offset 0x20, data 0x3C; then load 0x10;
- response: `Endereco`=0x10 on both accesses; `resp_dado`=0x3C.
REQ-025 Response backpressure:
- stimulus: load returning 0x77 with `resp_pronto`=0 for 5 cycles, then 1;
- response: `resp_valido` and `resp_dado`=0x77 stable for 6 cycles; `pronto`=0 throughout; `pronto`=1 on the next cycle.
REQ-026 Busy rejection:
- stimulus: `req_valido` held high with differing data during ESCRITA and LEITURA;
- response: those requests are not accepted and `Endereco` is unchanged.
REQ-027 Reset mid-operation:
- stimulus: reset in LEITURA;
- response: no `resp_valido`; all outputs at reset values; `pronto`=1 next cycle.
- stimulus: reset on the edge leaving ESCRITA of 0x5A to address 0x40;
- response: a later load of 0x40 returns 0x5A; `contador_acessos`=0x00.
REQ-028 Counter wrap:
- stimulus: 256 consecutive stores;
- response: `contador_acessos` returns to 0x00.
